// File: rtl/day11_pkg.sv
// Shared constants, FSM state encoding and helpers for the day-11 count stream transmitter.
package day11_pkg;

    localparam int WIDTH      = 64;
    localparam int NUM_COUNTS = 7;
    localparam int IDX_W      = 3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COUNTS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic idx_in_range(input logic [IDX_W-1:0] a);
        return (a <= LAST_IDX);
    endfunction

endpackage

// File: rtl/day11_count_table.sv
// NUM_COUNTS x WIDTH register file: one filtered write port, asynchronous read by index.
module day11_count_table
    import day11_pkg::*;
(
    input  logic             clock,
    input  logic             clear_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [NUM_COUNTS];
    logic [WIDTH-1:0] mem_d [NUM_COUNTS];

    // Next table contents: at most one entry replaced per cycle.
    always_comb begin
        for (int i = 0; i < NUM_COUNTS; i++) begin
            if (wr_en && (wr_addr == IDX_W'(i))) begin
                mem_d[i] = wr_data;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Table storage; reset zeroes every entry.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < NUM_COUNTS; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_COUNTS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read mux; an index with no entry behind it reads as zero.
    always_comb begin
        rd_data = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_COUNTS; i++) begin
            if (rd_addr == IDX_W'(i)) begin
                rd_data = mem_q[i];
            end else begin
                rd_data = rd_data;
            end
        end
    end

endmodule

// File: rtl/day11_count_stream_tx.sv
// Count stream transmitter: holds the path-count table, pulses load, then streams the
// entries in index order with valid/ready backpressure.
module day11_count_stream_tx
    import day11_pkg::*;
(
    input  logic             clock,
    input  logic             clear_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    output logic             load,
    output logic [WIDTH-1:0] count,
    output logic             count_valid,
    output logic             count_last,
    input  logic             ready,
    output logic [IDX_W-1:0] idx,
    output logic             busy,
    output logic             done_,
    output logic             wr_err
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             wr_err_q, wr_err_d;
    logic [1:0]       rst_sync_q, rst_sync_d;
    logic             rst_n_s;
    logic             busy_s, xfer_s, last_s, addr_ok_s, wr_ok_s, wr_bad_s;
    logic [WIDTH-1:0] rd_data_s;

    // Reset asserts immediately but releases two clocks later, aligned to the clock.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
        rst_n_s    = rst_sync_q[1];
    end

    // Reset release synchronizer.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    // Writes only land while the table is not being streamed.
    always_comb begin
        addr_ok_s = idx_in_range(wr_addr);
        xfer_s    = (state_q == SEND) && ready;
        last_s    = (idx_q == LAST_IDX);
        wr_ok_s   = wr_en && !busy_s && addr_ok_s;
        wr_bad_s  = wr_en && (busy_s || !addr_ok_s);
    end

    day11_count_table u_table (
        .clock   (clock),
        .clear_n (rst_n_s),
        .wr_en   (wr_ok_s),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx_q),
        .rd_data (rd_data_s)
    );

    // State register plus index and sticky flags.
    always_ff @(posedge clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q  <= IDLE;
            idx_q    <= {IDX_W{1'b0}};
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Next-state, index advance and flag updates.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        done_d   = done_q;
        wr_err_d = wr_err_q || wr_bad_s;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = SEND;
                idx_d   = {IDX_W{1'b0}};
            end
            SEND: begin
                if (xfer_s && last_s) begin
                    state_d = DONE;
                    idx_d   = {IDX_W{1'b0}};
                    done_d  = 1'b1;
                end else if (xfer_s) begin
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    idx_d = idx_q;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = LOAD;
                    done_d  = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Stream outputs decoded from the registered state; count is zero outside SEND.
    always_comb begin
        busy_s      = (state_q == LOAD) || (state_q == SEND);
        load        = (state_q == LOAD);
        count_valid = (state_q == SEND);
        count_last  = (state_q == SEND) && last_s;
        if (state_q == SEND) begin
            count = rd_data_s;
        end else begin
            count = {WIDTH{1'b0}};
        end
        idx    = idx_q;
        busy   = busy_s;
        done_  = done_q;
        wr_err = wr_err_q;
    end

endmodule

// File: tb/tb_day11_count_stream_tx.sv
// Scoreboard bench for day11_count_stream_tx: expected beats are queued at start and popped on transfer.
module tb_day11_count_stream_tx;
    import day11_pkg::*;

    typedef struct packed {
        logic [WIDTH-1:0] v;
        logic [IDX_W-1:0] i;
        logic             l;
    } beat_t;

    logic             clock = 1'b0;
    logic             clear_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [IDX_W-1:0] wr_addr = 3'd0;
    logic [WIDTH-1:0] wr_data = 64'd0;
    logic             start = 1'b0;
    logic             ready = 1'b0;
    logic             load, count_valid, count_last, busy, done_, wr_err;
    logic [WIDTH-1:0] count;
    logic [IDX_W-1:0] idx;

    beat_t            sb_q[$];
    logic [WIDTH-1:0] model_tbl [NUM_COUNTS];
    logic [WIDTH-1:0] recv [NUM_COUNTS];
    logic             exp_wr_err = 1'b0;
    int               checks = 0;
    int               errors = 0;

    day11_count_stream_tx dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .load        (load),
        .count       (count),
        .count_valid (count_valid),
        .count_last  (count_last),
        .ready       (ready),
        .idx         (idx),
        .busy        (busy),
        .done_       (done_),
        .wr_err      (wr_err)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic model_write(input logic [IDX_W-1:0] a, input logic [WIDTH-1:0] d, input bit busy_now);
        if (!busy_now && a <= LAST_IDX) model_tbl[a] = d;
        else exp_wr_err = 1'b1;
    endtask

    task automatic write_entry(input logic [IDX_W-1:0] a, input logic [WIDTH-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        model_write(a, d, 1'b0);
        tick;
        wr_en = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({load, count_valid, count_last, busy, done_, wr_err, idx, count} !== '0) begin
            errors++;
            $display("FAIL %s: outputs load=%0b valid=%0b last=%0b busy=%0b done=%0b wr_err=%0b idx=%0d count=%0h, required all 0",
                     name, load, count_valid, count_last, busy, done_, wr_err, idx, count);
        end
    endtask

    // mode 0: ready held high; mode 1: ready 1,0,0,1 repeating.
    task automatic send_frame(input int mode, input bit pre_wr, input logic [IDX_W-1:0] pre_addr,
                              input logic [WIDTH-1:0] pre_data, input int inj_wr, input int inj_start);
        int               cyc;
        int               n_xfer;
        int               extra_load;
        bit               stalled;
        beat_t            eb;
        logic [WIDTH-1:0] hold_c;
        logic [IDX_W-1:0] hold_i;
        if (pre_wr) begin
            wr_en = 1'b1; wr_addr = pre_addr; wr_data = pre_data;
            model_write(pre_addr, pre_data, 1'b0);
        end
        for (int k = 0; k < NUM_COUNTS; k++) begin
            eb.v = model_tbl[k]; eb.i = IDX_W'(k); eb.l = (k == NUM_COUNTS - 1);
            sb_q.push_back(eb);
        end
        start = 1'b1;
        tick;
        start = 1'b0; wr_en = 1'b0;
        checks++;
        if ({load, busy, count_valid, done_} !== 4'b1100) begin
            errors++;
            $display("FAIL load_cycle: load/busy/valid/done=%b required 1100", {load, busy, count_valid, done_});
        end
        tick;
        cyc = 0; n_xfer = 0; extra_load = 0; stalled = 0;
        while (count_valid === 1'b1 && cyc < 200) begin
            if (stalled) begin
                checks++;
                if (count !== hold_c || idx !== hold_i) begin
                    errors++;
                    $display("FAIL stall_hold: count=%0h idx=%0d required count=%0h idx=%0d", count, idx, hold_c, hold_i);
                end
            end
            ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (load) extra_load++;
            if (ready) begin
                stalled = 0;
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_beat: count=%0h idx=%0d required no beat", count, idx);
                end else begin
                    eb = sb_q.pop_front();
                    checks++;
                    if (count !== eb.v || idx !== eb.i || count_last !== eb.l) begin
                        errors++;
                        $display("FAIL beat: count=%0h idx=%0d last=%0b required count=%0h idx=%0d last=%0b",
                                 count, idx, count_last, eb.v, eb.i, eb.l);
                    end
                    if (n_xfer < NUM_COUNTS) recv[n_xfer] = count;
                    n_xfer++;
                end
            end else begin
                stalled = 1; hold_c = count; hold_i = idx;
            end
            wr_en = (cyc == inj_wr); wr_addr = 3'd0; wr_data = 64'hdead_beef;
            if (cyc == inj_wr) model_write(3'd0, 64'hdead_beef, 1'b1);
            start = (cyc == inj_start);
            tick;
            cyc++;
        end
        wr_en = 1'b0; start = 1'b0; ready = 1'b0;
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL frame_timeout: %0d cycles required under 200", cyc);
        end
        checks++;
        if (n_xfer != NUM_COUNTS || sb_q.size() != 0) begin
            errors++;
            $display("FAIL transfer_count: %0d transfers, %0d left required 7 and 0", n_xfer, sb_q.size());
        end
        sb_q.delete();
        if (mode == 0) begin
            checks++;
            if (cyc != NUM_COUNTS) begin
                errors++;
                $display("FAIL back_to_back: %0d send cycles required 7", cyc);
            end
        end
        checks++;
        if ({done_, busy, load, idx} !== {3'b100, 3'd0} || extra_load != 0) begin
            errors++;
            $display("FAIL frame_end: done=%0b busy=%0b load=%0b idx=%0d extra_load=%0d required 1 0 0 0 0",
                     done_, busy, load, idx, extra_load);
        end
        checks++;
        if (wr_err !== exp_wr_err) begin
            errors++;
            $display("FAIL wr_err: %0b required %0b", wr_err, exp_wr_err);
        end
    endtask

    task automatic test_reset;
        for (int k = 0; k < NUM_COUNTS; k++) model_tbl[k] = 64'd0;
        #3;
        check_all_zero("reset_asserted");
        tick; tick;
        clear_n = 1'b1;
        tick; tick; tick;
        check_all_zero("reset_released");
    endtask

    task automatic test_basic_frame;
        logic [WIDTH-1:0] vals [NUM_COUNTS];
        vals = '{64'd7, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd10};
        for (int k = 0; k < NUM_COUNTS; k++) write_entry(IDX_W'(k), vals[k]);
        send_frame(0, 1'b0, 3'd0, 64'd0, -1, -1);
        checks++;
        if (recv[0] !== 64'd7 || recv[6] !== 64'd10) begin
            errors++;
            $display("FAIL part1_and_last: first=%0d last=%0d required 7 and 10", recv[0], recv[6]);
        end
    endtask

    task automatic test_backpressure;
        send_frame(1, 1'b0, 3'd0, 64'd0, -1, -1);
    endtask

    task automatic test_start_while_busy;
        send_frame(1, 1'b0, 3'd0, 64'd0, -1, 2);
        send_frame(0, 1'b0, 3'd0, 64'd0, -1, -1);
    endtask

    task automatic test_write_while_busy;
        send_frame(0, 1'b0, 3'd0, 64'd0, 3, -1);
        send_frame(0, 1'b0, 3'd0, 64'd0, -1, -1);
    endtask

    task automatic test_reset_mid_frame;
        start = 1'b1;
        tick;
        start = 1'b0; ready = 1'b1;
        tick; tick; tick; tick;
        checks++;
        if (count_valid !== 1'b1 || idx !== 3'd3 || count !== 64'd4) begin
            errors++;
            $display("FAIL beat3_before_reset: valid=%0b idx=%0d count=%0h required 1 3 4", count_valid, idx, count);
        end
        clear_n = 1'b0;
        #1;
        check_all_zero("reset_mid_frame");
        for (int k = 0; k < NUM_COUNTS; k++) model_tbl[k] = 64'd0;
        exp_wr_err = 1'b0;
        ready = 1'b0;
        tick;
        clear_n = 1'b1;
        tick; tick; tick;
        check_all_zero("after_mid_reset");
        send_frame(0, 1'b0, 3'd0, 64'd0, -1, -1);
    endtask

    task automatic test_bad_addr;
        write_entry(3'd7, 64'd99);
        checks++;
        if (wr_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_addr_wr_err: %0b required 1", wr_err);
        end
        send_frame(0, 1'b0, 3'd0, 64'd0, -1, -1);
    endtask

    task automatic test_write_with_start;
        send_frame(0, 1'b1, 3'd0, 64'd5, -1, -1);
        checks++;
        if (recv[0] !== 64'd5) begin
            errors++;
            $display("FAIL write_with_start: first beat %0d required 5", recv[0]);
        end
    endtask

    initial begin
        test_reset;
        test_basic_frame;
        test_backpressure;
        test_start_while_busy;
        test_write_while_busy;
        test_reset_mid_frame;
        test_bad_addr;
        test_write_with_start;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
